// File: rtl/fifo_unpack_pkg.sv
// Shared types and helpers for the wide-to-narrow FIFO word unpacker.
// Provides the unpacker state encoding and the lane-count decode.
package fifo_unpack_pkg;

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   localparam int unsigned DEF_RATIO  = 4;
   localparam int unsigned LANE_IDX_W = $clog2(DEF_RATIO);

   // A lane count of zero means a full word of ratio lanes.
   function automatic int unsigned decode_nlanes(input int unsigned nlanes,
                                                 input int unsigned ratio);
      return (nlanes == 0) ? ratio : nlanes;
   endfunction

endpackage

// File: rtl/fifo_word_unpacker_lane_mux.sv
// Combinational lane selector: picks lane idx out of a wide word, in either
// LS-lane-first or MS-lane-first emission order.
module lane_mux
   import fifo_unpack_pkg::*;
#(
   parameter int unsigned in_width  = 32,
   parameter int unsigned out_width = 8,
   parameter int unsigned ratio     = 4,
   parameter bit          lsb_first = 1'b1,
   parameter int unsigned cw        = LANE_IDX_W
) (
   input  logic [in_width-1:0]  word,
   input  logic [cw-1:0]        idx,
   output logic [out_width-1:0] lane
);

   logic [cw-1:0] sel;

   always_comb begin
      sel  = lsb_first ? idx : (cw'(ratio - 1) - idx);
      lane = '0;
      for (int unsigned i = 0; i < ratio; i++) begin
         if (cw'(i) == sel) lane = word[i*out_width +: out_width];
      end
   end

endmodule

// File: rtl/fifo_word_unpacker.sv
// Wide-to-narrow gearbox between a FIFO head (DEQ/EMPTY_N) and a downstream
// FIFO (ENQ/FULL_N); emits one lane per cycle with no bubble between words.
module fifo_word_unpacker
   import fifo_unpack_pkg::*;
#(
   parameter int unsigned in_width  = 32,
   parameter int unsigned out_width = 8,
   parameter int unsigned ratio     = 4,
   parameter bit          lsb_first = 1'b1,
   parameter int unsigned cw        = LANE_IDX_W
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLR,
   input  logic [in_width-1:0]  IN_D,
   input  logic [cw-1:0]        IN_NLANES,
   input  logic                 IN_LAST,
   input  logic                 IN_EMPTY_N,
   output logic                 IN_DEQ,
   output logic [out_width-1:0] OUT_D,
   output logic                 OUT_LAST,
   output logic                 OUT_ENQ,
   input  logic                 OUT_FULL_N
);

   if (ratio * out_width != in_width) begin : g_geom_warn
      $warning("fifo_word_unpacker: ratio*out_width does not equal in_width");
   end

   state_t                state, state_next;
   logic [in_width-1:0]   held_d;
   logic                  held_last;
   logic [cw-1:0]         idx;
   logic [cw-1:0]         last_idx;
   logic                  emit, at_end, enq, load;

   always_comb begin
      emit       = (state == EMIT);
      at_end     = (idx == last_idx);
      enq        = emit & OUT_FULL_N & ~RST & ~CLR;
      // Refill on the final lane's enqueue so consecutive words leave no gap.
      load       = IN_EMPTY_N & ~RST & ~CLR & (~emit | (enq & at_end));
      state_next = state;
      if (RST || CLR)        state_next = IDLE;
      else if (load)         state_next = EMIT;
      else if (enq && at_end) state_next = IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge CLK) begin
      if (RST || CLR)            idx <= '0;
      else if (load)             idx <= '0;
      else if (enq && !at_end)   idx <= idx + 1'b1;
   end

   // Word storage is deliberately left unreset; it is only read while in EMIT.
   always_ff @(posedge CLK) begin
      if (load) begin
         held_d    <= IN_D;
         held_last <= IN_LAST;
         last_idx  <= cw'(decode_nlanes(32'(IN_NLANES), ratio) - 1);
      end
   end

   lane_mux #(
      .in_width (in_width),
      .out_width(out_width),
      .ratio    (ratio),
      .lsb_first(lsb_first),
      .cw       (cw)
   ) u_lane_mux (
      .word(held_d),
      .idx (idx),
      .lane(OUT_D)
   );

   assign IN_DEQ   = load;
   assign OUT_ENQ  = enq;
   assign OUT_LAST = emit & held_last & at_end;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Self-checking bench: two unpackers (LS-first and MS-first) share stimulus and
// are compared each cycle against a lane-queue reference model.
module tb_fifo_word_unpacker;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  nl;
      logic        last;
   } word_t;

   typedef struct {
      logic [7:0] d1;
      logic [7:0] d0;
      logic       last;
   } lane_t;

   typedef logic [7:0] byte_q_t[$];

   logic        CLK = 1'b0;
   logic        RST, CLR, IN_LAST, IN_EMPTY_N, OUT_FULL_N;
   logic [31:0] IN_D;
   logic [1:0]  IN_NLANES;
   logic        deq1, enq1, last1, deq0, enq0, last0;
   logic [7:0]  d1, d0;

   word_t       src[$];
   lane_t       pend[$];
   byte_q_t     emitted1, emitted0, lasts;
   int          enq_cyc[$];
   int          deq_log[$];
   int          cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        em, exp_enq, exp_deq;
   logic [21:0] exp;

   always #5 CLK = ~CLK;

   fifo_word_unpacker #(.in_width(32), .out_width(8), .ratio(4), .lsb_first(1'b1), .cw(2)) dut_ls (
      .CLK(CLK), .RST(RST), .CLR(CLR), .IN_D(IN_D), .IN_NLANES(IN_NLANES), .IN_LAST(IN_LAST),
      .IN_EMPTY_N(IN_EMPTY_N), .IN_DEQ(deq1), .OUT_D(d1), .OUT_LAST(last1), .OUT_ENQ(enq1),
      .OUT_FULL_N(OUT_FULL_N));

   fifo_word_unpacker #(.in_width(32), .out_width(8), .ratio(4), .lsb_first(1'b0), .cw(2)) dut_ms (
      .CLK(CLK), .RST(RST), .CLR(CLR), .IN_D(IN_D), .IN_NLANES(IN_NLANES), .IN_LAST(IN_LAST),
      .IN_EMPTY_N(IN_EMPTY_N), .IN_DEQ(deq0), .OUT_D(d0), .OUT_LAST(last0), .OUT_ENQ(enq0),
      .OUT_FULL_N(OUT_FULL_N));

   function automatic logic [63:0] pack8(input byte_q_t q);
      logic [63:0] r = '0;
      for (int i = 0; i < q.size(); i++) r = {r[55:0], q[i]};
      return r;
   endfunction

   // Lane data is only meaningful while the model holds a word.
   function automatic logic [21:0] observe();
      return {deq1, enq1, last1, em ? d1 : 8'h00, deq0, enq0, last0, em ? d0 : 8'h00};
   endfunction

   task automatic push_word(input logic [31:0] d, input logic [1:0] nl, input logic last);
      src.push_back('{d: d, nl: nl, last: last});
   endtask

   task automatic clear_logs();
      emitted1.delete(); emitted0.delete(); lasts.delete();
      enq_cyc.delete(); deq_log.delete();
   endtask

   task automatic prep();
      em = (pend.size() != 0);
      if (src.size() != 0) begin
         IN_EMPTY_N = 1'b1; IN_D = src[0].d; IN_NLANES = src[0].nl; IN_LAST = src[0].last;
      end else begin
         IN_EMPTY_N = 1'b0; IN_D = $urandom; IN_NLANES = 2'($urandom); IN_LAST = 1'($urandom);
      end
      exp_enq = em && OUT_FULL_N && !RST && !CLR;
      exp_deq = IN_EMPTY_N && !RST && !CLR && (!em || (exp_enq && pend.size() == 1));
      if (em) exp = {exp_deq, exp_enq, pend[0].last, pend[0].d1, exp_deq, exp_enq, pend[0].last, pend[0].d0};
      else    exp = {exp_deq, exp_enq, 1'b0, 8'h00, exp_deq, exp_enq, 1'b0, 8'h00};
      #4;
   endtask

   task automatic commit();
      word_t w;
      int    n;
      if (enq1) begin
         emitted1.push_back(d1); emitted0.push_back(d0); lasts.push_back({7'd0, last1});
         enq_cyc.push_back(cyc);
      end
      if (deq1) deq_log.push_back(cyc);
      @(posedge CLK);
      if (RST || CLR) pend.delete();
      else begin
         if (exp_enq) pend.delete(0);
         if (exp_deq) begin
            w = src.pop_front();
            n = (w.nl == 0) ? 4 : int'(w.nl);
            for (int i = 0; i < n; i++)
               pend.push_back('{d1: w.d[8*i +: 8], d0: w.d[8*(3-i) +: 8], last: w.last && (i == n-1)});
         end
      end
      cyc++;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      clear_logs();
      push_word(32'hDDCCBBAA, 2'd0, 1'b1);
      RST = 1'b1;
      for (int k = 0; k < 2; k++) begin
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
      RST = 1'b0;
      prep();
      if (deq1 !== 1'b1) begin n_bad++; $display("FAIL reset_first_deq got=%b exp=1", deq1); end
      n_cmp++;
      commit();
      for (int k = 0; k < 6; k++) begin
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL reset_drain cyc=%0d got=%h exp=%h", cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
   endtask

   task automatic test_single();
      clear_logs();
      push_word(32'hDDCCBBAA, 2'd0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
      n_cmp++;
      if (emitted1.size() != 4 || pack8(emitted1) !== 64'hAABBCCDD) begin
         n_bad++; $display("FAIL single_lanes got=%h n=%0d exp=AABBCCDD n=4", pack8(emitted1), emitted1.size());
      end
      n_cmp++;
      if (emitted0.size() != 4 || pack8(emitted0) !== 64'hDDCCBBAA) begin
         n_bad++; $display("FAIL msb_first_lanes got=%h exp=DDCCBBAA", pack8(emitted0));
      end
      n_cmp++;
      if (pack8(lasts) !== 64'h00000001) begin n_bad++; $display("FAIL single_last got=%h exp=00000001", pack8(lasts)); end
      n_cmp++;
      if (deq_log.size() != 1 || enq_cyc.size() != 4 || enq_cyc[3] - enq_cyc[0] != 3) begin
         n_bad++; $display("FAIL single_timing deqs=%0d enqs=%0d exp deqs=1 enqs=4 consecutive", deq_log.size(), enq_cyc.size());
      end
   endtask

   task automatic test_back_to_back();
      clear_logs();
      push_word(32'h44332211, 2'd0, 1'b0);
      push_word(32'h88776655, 2'd0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
      n_cmp++;
      if (emitted1.size() != 8 || pack8(emitted1) !== 64'h1122334455667788) begin
         n_bad++; $display("FAIL b2b_lanes got=%h exp=1122334455667788", pack8(emitted1));
      end
      n_cmp++;
      if (enq_cyc.size() != 8 || deq_log.size() != 2 || enq_cyc[7] - enq_cyc[0] != 7 || deq_log[1] != enq_cyc[3]) begin
         n_bad++; $display("FAIL b2b_timing enqs=%0d deqs=%0d exp 8 consecutive, 2nd deq with lane 44", enq_cyc.size(), deq_log.size());
      end
   endtask

   task automatic test_partial();
      clear_logs();
      push_word(32'h00CCBBAA, 2'd3, 1'b1);
      for (int k = 0; k < 8; k++) begin
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL partial cyc=%0d got=%h exp=%h", cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
      n_cmp++;
      if (emitted1.size() != 3 || pack8(emitted1) !== 64'hAABBCC || pack8(lasts) !== 64'h000001) begin
         n_bad++; $display("FAIL partial_lanes got=%h last=%h exp=AABBCC last=000001", pack8(emitted1), pack8(lasts));
      end
   endtask

   task automatic test_backpressure();
      int hold = 0;
      clear_logs();
      push_word(32'hDDCCBBAA, 2'd0, 1'b0);
      push_word(32'h44332211, 2'd0, 1'b1);
      for (int k = 0; k < 16; k++) begin
         OUT_FULL_N = !(emitted1.size() == 2 && hold < 3);
         if (!OUT_FULL_N) hold++;
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
      OUT_FULL_N = 1'b1;
      n_cmp++;
      if (emitted1.size() != 8 || pack8(emitted1) !== 64'hAABBCCDD11223344) begin
         n_bad++; $display("FAIL backpressure_lanes got=%h exp=AABBCCDD11223344", pack8(emitted1));
      end
      n_cmp++;
      if (enq_cyc.size() != 8 || enq_cyc[2] - enq_cyc[1] != 4 || deq_log.size() != 2) begin
         n_bad++; $display("FAIL backpressure_timing enqs=%0d deqs=%0d exp gap 4 after lane 1", enq_cyc.size(), deq_log.size());
      end
   endtask

   task automatic test_abort(input bit use_rst);
      bit fired = 1'b0;
      int abort_cyc = 0;
      clear_logs();
      push_word(32'hDDCCBBAA, 2'd0, 1'b1);
      push_word(32'h44332211, 2'd0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         RST = 1'b0; CLR = 1'b0;
         if (emitted1.size() == 2 && !fired) begin
            fired = 1'b1; abort_cyc = cyc;
            if (use_rst) RST = 1'b1; else CLR = 1'b1;
         end
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL abort rst=%0b cyc=%0d got=%h exp=%h", use_rst, cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
      RST = 1'b0; CLR = 1'b0;
      n_cmp++;
      if (emitted1.size() != 6 || pack8(emitted1) !== 64'hAABB11223344 || pack8(emitted0) !== 64'hDDCC44332211) begin
         n_bad++; $display("FAIL abort_lanes rst=%0b got=%h/%h exp=AABB11223344/DDCC44332211", use_rst, pack8(emitted1), pack8(emitted0));
      end
      n_cmp++;
      if (enq_cyc.size() != 6 || enq_cyc[2] - abort_cyc != 2) begin
         n_bad++; $display("FAIL abort_latency rst=%0b enqs=%0d exp lane 11 two cycles after abort", use_rst, enq_cyc.size());
      end
   endtask

   task automatic test_random();
      clear_logs();
      for (int k = 0; k < 500; k++) begin
         if (src.size() < 2 && $urandom_range(0, 3) != 0)
            push_word($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         OUT_FULL_N = ($urandom_range(0, 3) != 0);
         CLR        = ($urandom_range(0, 39) == 0);
         RST        = ($urandom_range(0, 99) == 0);
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
      RST = 1'b0; CLR = 1'b0; OUT_FULL_N = 1'b1;
      for (int k = 0; k < 12; k++) begin
         prep();
         if (observe() !== exp) begin n_bad++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, observe(), exp); end
         n_cmp++;
         commit();
      end
   endtask

   initial begin
      RST = 1'b1; CLR = 1'b0; OUT_FULL_N = 1'b1;
      IN_D = '0; IN_NLANES = '0; IN_LAST = 1'b0; IN_EMPTY_N = 1'b0;
      @(negedge CLK);
      test_reset();
      test_single();
      test_back_to_back();
      test_partial();
      test_backpressure();
      test_abort(1'b0);
      test_abort(1'b1);
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
